icache_line_controller: RTL and testbench

- Tag/valid store and miss-handling FSM for a 16-line, direct-mapped instruction cache with 128-bit lines.
- The line data lives in an external 16 x 128-bit data array, read through the 16:1 128-bit line mux.
- This block drives the mux select and the data-array write strobe, extracts the 32-bit instruction from the selected line, and runs the refill handshake with instruction memory.
- It sits between the IF stage PC and the instruction memory.

---
 rtl/icache_line_controller_pkg.sv | 31 +++
 rtl/icache_line_controller_tag.sv | 49 ++++
 rtl/icache_line_controller.sv | 132 +++++++++++++
 tb/tb_icache_line_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_line_controller_pkg.sv
// -----------------------------------------------------------------------------
// icache_line_controller_pkg
// Shared constants and types for the direct-mapped instruction cache line
// controller: geometry, address field positions, refill FSM state encoding.
// -----------------------------------------------------------------------------
package icache_line_controller_pkg;

  localparam int LINES       = 16;
  localparam int IDX_W       = 4;
  localparam int TAG_W       = 24;
  localparam int LINE_W      = 128;
  localparam int WORD_W      = 32;
  localparam int BLK_W       = 28;
  localparam int CNT_W       = 8;
  localparam int MEM_LAT_MAX = 255;

  // Address field positions within the 32-bit fetch PC.
  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 8;
  localparam int IDX_MSB  = 7;
  localparam int IDX_LSB  = 4;
  localparam int WORD_MSB = 3;
  localparam int WORD_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

endpackage

// File: rtl/icache_line_controller_tag.sv
// -----------------------------------------------------------------------------
// icache_tag_store
// 16-entry tag + valid store for the direct-mapped instruction cache.
//   clk_i      : clock, all updates on the rising edge
//   clr_n_i    : synchronous active-low clear of every valid bit (wins over write)
//   we_i       : write strobe; tag[wr_idx_i] <= wr_tag_i, valid[wr_idx_i] <= 1
//   wr_idx_i   : line written
//   wr_tag_i   : tag written
//   rd_idx_i   : line looked up
//   rd_tag_i   : tag compared against the stored tag
//   hit_o      : combinational valid && tag match for rd_idx_i
// -----------------------------------------------------------------------------
module icache_tag_store
  import icache_line_controller_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             hit_o
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: the tag array has no reset; a stale tag is harmless because the
  // valid bit gates every hit, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/icache_line_controller.sv
// -----------------------------------------------------------------------------
// icache_line_controller
// Tag/valid store and miss-handling FSM for a 16-line direct-mapped I-cache
// with 128-bit lines held in an external data array.
//   CLK          : clock
//   RESET        : synchronous active-low reset
//   ADDRESS      : fetch PC (held stable by the pipeline while BUSYWAIT=1)
//   FLUSH        : invalidate all lines (honoured in IDLE only)
//   LINE_DATA    : data array line selected by LINE_SELECT
//   LINE_SELECT  : data array read/write index = ADDRESS[7:4]
//   DATA_WRITE   : one-cycle write strobe to the data array (UPDATE state)
//   INSTRUCTION  : word ADDRESS[3:2] of LINE_DATA
//   BUSYWAIT     : pipeline stall
//   MEM_READ     : refill request
//   MEM_ADDRESS  : refill block address {tag, index}
//   MEM_BUSYWAIT : memory busy; refill completes on the first low cycle
//   MEM_TIMEOUT  : sticky flag, set when a refill waits MEM_LAT_MAX cycles
// -----------------------------------------------------------------------------
module icache_line_controller
  import icache_line_controller_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       ADDRESS,
  input  logic              FLUSH,
  input  logic [LINE_W-1:0] LINE_DATA,
  output logic [IDX_W-1:0]  LINE_SELECT,
  output logic              DATA_WRITE,
  output logic [WORD_W-1:0] INSTRUCTION,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic [BLK_W-1:0]  MEM_ADDRESS,
  input  logic              MEM_BUSYWAIT,
  output logic              MEM_TIMEOUT
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             flush_clr;
  logic             hit;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [1:0]       addr_word;

  assign addr_tag  = ADDRESS[TAG_MSB:TAG_LSB];
  assign addr_idx  = ADDRESS[IDX_MSB:IDX_LSB];
  assign addr_word = ADDRESS[WORD_MSB:WORD_LSB];

  // Reset and an IDLE flush share the tag store's synchronous valid clear.
  icache_tag_store u_tag_store (
    .clk_i    (CLK),
    .clr_n_i  (RESET && !flush_clr),
    .we_i     (DATA_WRITE),
    .wr_idx_i (addr_idx),
    .wr_tag_i (addr_tag),
    .rd_idx_i (addr_idx),
    .rd_tag_i (addr_tag),
    .hit_o    (hit)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    BUSYWAIT   = 1'b1;
    MEM_READ   = 1'b0;
    DATA_WRITE = 1'b0;
    flush_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        BUSYWAIT = !hit;
        if (FLUSH) begin
          flush_clr = 1'b1;
          BUSYWAIT  = 1'b1;
        end else if (!hit) begin
          state_d = ST_MEM_READ;
          cnt_d   = '0;
        end
      end
      ST_MEM_READ: begin
        MEM_READ = 1'b1;
        // The flag only reports a slow memory; the refill keeps waiting.
        if (cnt_q == CNT_W'(MEM_LAT_MAX)) begin
          timeout_d = 1'b1;
        end
        if (!MEM_BUSYWAIT) begin
          state_d = ST_UPDATE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_W'(MEM_LAT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        DATA_WRITE = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign LINE_SELECT = addr_idx;
  assign MEM_ADDRESS = ADDRESS[TAG_MSB:IDX_LSB];
  assign MEM_TIMEOUT = timeout_q;

  always_comb begin
    unique case (addr_word)
      2'd0:    INSTRUCTION = LINE_DATA[31:0];
      2'd1:    INSTRUCTION = LINE_DATA[63:32];
      2'd2:    INSTRUCTION = LINE_DATA[95:64];
      default: INSTRUCTION = LINE_DATA[127:96];
    endcase
  end

endmodule

// File: tb/tb_icache_line_controller.sv
module tb_icache_line_controller;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  ADDRESS;
  logic         FLUSH;
  logic [127:0] LINE_DATA;
  logic [3:0]   LINE_SELECT;
  logic         DATA_WRITE;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic         MEM_BUSYWAIT;
  logic         MEM_TIMEOUT;

  icache_line_controller dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .FLUSH        (FLUSH),
    .LINE_DATA    (LINE_DATA),
    .LINE_SELECT  (LINE_SELECT),
    .DATA_WRITE   (DATA_WRITE),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .MEM_TIMEOUT  (MEM_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Instruction memory contents: a fixed pattern per 16-byte block.
  function automatic logic [127:0] mem_line(input logic [27:0] b);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) begin
      l[32*i +: 32] = ({b, 4'(i)} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    end
    return l;
  endfunction

  // External 16 x 128 data array, written on DATA_WRITE with the block the
  // memory returned.
  logic [127:0] arr [16];
  logic [27:0]  mem_cap;
  initial begin
    for (int i = 0; i < 16; i++) arr[i] = '0;
    mem_cap = '0;
  end
  always @(posedge CLK) if (DATA_WRITE) arr[LINE_SELECT] <= mem_line(mem_cap);
  assign LINE_DATA = arr[LINE_SELECT];

  // Reference cache model and scoreboard.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          stalls;
    bit          miss;
    bit          to;
  } exp_t;
  exp_t        sbq[$];
  bit          mv [16];
  logic [23:0] mt [16];
  bit          m_to = 1'b0;
  int          mem_lat = 1;
  bit          fetch_active = 1'b0;

  // Memory: drops MEM_BUSYWAIT on the mem_lat-th cycle of a request.
  initial begin
    int k;
    k = 0;
    MEM_BUSYWAIT = 1'b1;
    forever begin
      @(negedge CLK);
      if (!MEM_READ) begin
        k = 0;
        MEM_BUSYWAIT = 1'b1;
      end else begin
        k++;
        if (k >= mem_lat) begin
          MEM_BUSYWAIT = 1'b0;
          mem_cap = MEM_ADDRESS;
          if (fetch_active && sbq.size() > 0) check("mem_address", MEM_ADDRESS, sbq[0].addr[31:4]);
        end else begin
          MEM_BUSYWAIT = 1'b1;
        end
      end
    end
  end

  // Monitor: counts stall cycles of the active fetch and compares on delivery.
  initial begin
    int  stalls;
    int  dws;
    bit  saw_mr;
    exp_t e;
    stalls = 0; dws = 0; saw_mr = 1'b0;
    forever begin
      @(negedge CLK);
      if (fetch_active) begin
        if (MEM_READ) saw_mr = 1'b1;
        if (DATA_WRITE) begin
          dws++;
          if (sbq.size() > 0) check("dw_line_select", LINE_SELECT, sbq[0].addr[7:4]);
        end
        if (BUSYWAIT) begin
          stalls++;
        end else if (sbq.size() == 0) begin
          check("scoreboard_nonempty", 0, 1);
          fetch_active = 1'b0;
        end else begin
          e = sbq.pop_front();
          check($sformatf("instr@%08h", e.addr), INSTRUCTION, e.instr);
          check($sformatf("stalls@%08h", e.addr), stalls, e.stalls);
          check($sformatf("mem_read_seen@%08h", e.addr), saw_mr, e.miss);
          check($sformatf("dw_pulses@%08h", e.addr), dws, e.miss ? 1 : 0);
          check($sformatf("timeout@%08h", e.addr), MEM_TIMEOUT, e.to);
          stalls = 0; dws = 0; saw_mr = 1'b0;
          fetch_active = 1'b0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the fetch is delivered.
  task automatic fetch(input logic [31:0] a, input int lat, input bit flush_mid = 1'b0);
    exp_t         e;
    logic [3:0]   idx;
    logic [23:0]  tag;
    logic [127:0] l;
    bit           hit;
    idx = a[7:4];
    tag = a[31:8];
    hit = mv[idx] && (mt[idx] == tag);
    l = mem_line(a[31:4]);
    e.addr   = a;
    e.instr  = l[32*a[3:2] +: 32];
    e.miss   = !hit;
    e.stalls = hit ? 0 : 2 + lat;
    if (!hit) begin
      mv[idx] = 1'b1;
      mt[idx] = tag;
      if (lat >= 256) m_to = 1'b1;
    end
    e.to = m_to;
    sbq.push_back(e);
    mem_lat = lat;
    ADDRESS = a;
    fetch_active = 1'b1;
    if (flush_mid && !hit) begin
      @(posedge CLK); @(posedge CLK); #1 FLUSH = 1'b1;
      @(posedge CLK); #1 FLUSH = 1'b0;
    end
    for (int c = 0; c < 2000 && fetch_active; c++) @(posedge CLK);
    if (fetch_active) begin
      check($sformatf("fetch_completes@%08h", a), 1'b0, 1'b1);
      fetch_active = 1'b0;
      sbq.delete();
    end
    #1;
  endtask

  // One-cycle IDLE flush; the caller must issue a fetch right after.
  task automatic do_flush();
    FLUSH = 1'b1;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    @(posedge CLK); #1 FLUSH = 1'b0;
  endtask

  task automatic reset_post_checks();
    fork
      begin
        @(negedge CLK);
        check("rst_mem_read", MEM_READ, 1'b0);
        check("rst_data_write", DATA_WRITE, 1'b0);
        check("rst_timeout", MEM_TIMEOUT, 1'b0);
        check("rst_busywait", BUSYWAIT, 1'b1);
      end
    join_none
  endtask

  initial begin
    logic [23:0] tags [4];
    logic [31:0] a;
    tags[0] = 24'h000000; tags[1] = 24'h000010; tags[2] = 24'h0000AB; tags[3] = 24'h001234;
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mt[i] = '0; end
    RESET = 1'b0; FLUSH = 1'b0; ADDRESS = 32'h0000_0040;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    check("reset_mem_read", MEM_READ, 1'b0);
    check("reset_data_write", DATA_WRITE, 1'b0);
    check("reset_timeout", MEM_TIMEOUT, 1'b0);
    check("reset_busywait", BUSYWAIT, 1'b1);
    check("reset_line_select", LINE_SELECT, 4'h4);
    @(posedge CLK); #1 RESET = 1'b1;

    // First refill, then hits on the remaining words.
    fetch(32'h0000_0040, 3);
    fetch(32'h0000_0044, 3);
    fetch(32'h0000_0048, 3);
    fetch(32'h0000_004C, 3);

    // Conflict on index 4, then the original tag misses again.
    fetch(32'h0000_1040, 2);
    fetch(32'h0000_0040, 3);

    // Flush in IDLE, then a flush during MEM_READ that must be ignored.
    do_flush();
    fetch(32'h0000_0040, 1);
    fetch(32'h0000_0080, 4, 1'b1);
    fetch(32'h0000_0084, 4);
    fetch(32'h0000_0044, 4);

    // Slow memory: flag sets, refill completes, flag stays set.
    fetch(32'h0000_2000, 257);
    fetch(32'h0000_2004, 2);
    fetch(32'h0000_3000, 2);

    // Reset in the middle of a refill abandons it.
    ADDRESS = 32'h0000_5040;
    mem_lat = 20;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK); #1 RESET = 1'b1;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    m_to = 1'b0;
    reset_post_checks();
    fetch(32'h0000_5040, 3);
    fetch(32'h0000_5044, 3);

    // Randomized traffic over a few conflicting tags.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) do_flush();
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      fetch(a, $urandom_range(1, 6));
    end

    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
